// File: rtl/period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk cycles.
// Optional high-time capture is compiled in with PERIOD_METER_DUTY_EN.
module period_meter #(
    parameter int CNT_W   = 27,
    parameter int TIMEOUT = 100_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_CNT     = CNT_W'(1);

    typedef enum logic [1:0] {
        ARM,
        MEASURE,
        STALLED
    } state_t;

    state_t           state;
    logic             s1;
    logic             s2;
    logic             s3;
    logic             rise;
    logic [CNT_W-1:0] cnt;

    assign rise = s2 & ~s3;

`ifdef PERIOD_METER_DUTY_EN
    logic             fall;
    logic [CNT_W-1:0] hi_tmp;

    assign fall = ~s2 & s3;

    // Only falls that follow an armed rise belong to a period we will report.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_tmp <= '0;
        end else if (state == MEASURE && fall) begin
            hi_tmp <= cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            high_time <= '0;
        end else if (state == MEASURE && rise) begin
            high_time <= hi_tmp;
        end
    end
`else
    assign high_time = '0;
`endif

    // The counter saturates at TIMEOUT, which also makes it hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1           <= 1'b0;
            s2           <= 1'b0;
            s3           <= 1'b0;
            cnt          <= '0;
            state        <= ARM;
            period       <= '0;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            s1           <= sig_in;
            s2           <= s1;
            s3           <= s2;
            period_valid <= 1'b0;

            if (rise) begin
                cnt <= ONE_CNT;
            end else if (cnt != TIMEOUT_CNT) begin
                cnt <= cnt + ONE_CNT;
            end

            case (state)
                ARM: begin
                    if (rise) begin
                        state <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period       <= cnt;
                        period_valid <= 1'b1;
                    end else if (cnt == TIMEOUT_CNT) begin
                        state   <= STALLED;
                        timeout <= 1'b1;
                    end
                end
                STALLED: begin
                    if (rise) begin
                        timeout <= 1'b0;
                        state   <= MEASURE;
                    end
                end
                default: begin
                    state <= ARM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// Directed self-checking bench for period_meter (CNT_W = 8, TIMEOUT = 20).
// Expected high time follows the PERIOD_METER_DUTY_EN build option.
module tb_period_meter;

    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 20;
`ifdef PERIOD_METER_DUTY_EN
    localparam int HI = 4;
`else
    localparam int HI = 0;
`endif

    logic             clk;
    logic             rst;
    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             period_valid;
    logic             timeout;

    int tests;
    int failures;
    int pulses;

    period_meter #(
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sig_in      (sig_in),
        .period      (period),
        .high_time   (high_time),
        .period_valid(period_valid),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (period_valid === 1'b1) begin
            pulses++;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        sig_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One input period: checks one cycle before and at the edge where a rise is acted on.
    task automatic apply_stimulus(input int hi, input int lo, input logic to_pre, input logic pulse,
                                  input int exp_p, input int exp_h, input logic to_post,
                                  input string tag);
        hold(1'b1, 2);
        check_output({tag, ".valid_pre"}, 32'(period_valid), 32'd0);
        check_output({tag, ".timeout_pre"}, 32'(timeout), 32'(to_pre));
        hold(1'b1, 1);
        check_output({tag, ".valid"}, 32'(period_valid), 32'(pulse));
        check_output({tag, ".period"}, 32'(period), 32'(exp_p));
        check_output({tag, ".high_time"}, 32'(high_time), 32'(exp_h));
        check_output({tag, ".timeout"}, 32'(timeout), 32'(to_post));
        hold(1'b1, hi - 3);
        hold(1'b0, lo);
    endtask

    initial begin
        tests    = 0;
        failures = 0;
        pulses   = 0;
        rst      = 1'b1;
        sig_in   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_output("reset.period", 32'(period), 32'd0);
        check_output("reset.high_time", 32'(high_time), 32'd0);
        check_output("reset.valid", 32'(period_valid), 32'd0);
        check_output("reset.timeout", 32'(timeout), 32'd0);
        hold(1'b0, 3);

        // Steady wave: period 10, high 4; the first rise only arms.
        apply_stimulus(4, 6, 1'b0, 1'b0, 0, 0, 1'b0, "arm");
        apply_stimulus(4, 6, 1'b0, 1'b1, 10, HI, 1'b0, "steady1");
        apply_stimulus(4, 6, 1'b0, 1'b1, 10, HI, 1'b0, "steady2");
        apply_stimulus(4, 6, 1'b0, 1'b1, 10, HI, 1'b0, "steady3");
        check_output("steady.pulses", 32'(pulses), 32'd3);

        // Stall: last rise acted on at edge k+2, timeout appears at edge k+22.
        hold(1'b0, 12);
        check_output("stall.timeout_early", 32'(timeout), 32'd0);
        hold(1'b0, 1);
        check_output("stall.timeout", 32'(timeout), 32'd1);
        check_output("stall.period_held", 32'(period), 32'd10);
        hold(1'b0, 5);
        check_output("stall.timeout_held", 32'(timeout), 32'd1);
        check_output("stall.valid", 32'(period_valid), 32'd0);
        apply_stimulus(4, 8, 1'b1, 1'b0, 10, HI, 1'b0, "recover");
        apply_stimulus(4, 16, 1'b0, 1'b1, 12, HI, 1'b0, "after_stall");

        // Boundary: 20 cycles apart reports, 21 apart stalls.
        apply_stimulus(4, 17, 1'b0, 1'b1, 20, HI, 1'b0, "edge20");
        apply_stimulus(4, 6, 1'b1, 1'b0, 20, HI, 1'b0, "edge21");
        apply_stimulus(4, 6, 1'b0, 1'b1, 10, HI, 1'b0, "post21");

        // Reset five cycles after a reported rise.
        hold(1'b1, 3);
        check_output("partial.valid", 32'(period_valid), 32'd1);
        check_output("partial.period", 32'(period), 32'd10);
        hold(1'b1, 1);
        hold(1'b0, 3);
        rst = 1'b1;
        hold(1'b0, 1);
        rst = 1'b0;
        check_output("midreset.period", 32'(period), 32'd0);
        check_output("midreset.high_time", 32'(high_time), 32'd0);
        check_output("midreset.valid", 32'(period_valid), 32'd0);
        check_output("midreset.timeout", 32'(timeout), 32'd0);
        hold(1'b0, 3);
        apply_stimulus(4, 6, 1'b0, 1'b0, 0, 0, 1'b0, "rearm");
        apply_stimulus(4, 6, 1'b0, 1'b1, 10, HI, 1'b0, "rearm_report");

        check_output("total.pulses", 32'(pulses), 32'd8);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/period_meter.md
# period_meter

Measures the period and high time of a slow, asynchronous square-wave input, such as the 1 Hz divided clock, in cycles of the 50 MHz system clock. It is the receiving end of the clock-divider output: it checks a generated slow clock on hardware and feeds LED/seven-segment debug logic. Results are updated once per input period and flagged with a one-cycle valid pulse. A timeout flag indicates a stalled input.

## Interface
- `CNT_W`, default 27: width of the cycle counter and the result outputs.
- `TIMEOUT`, default 100_000_000: maximum cycles between rising edges before a stall is declared. Must satisfy 2 ≤ TIMEOUT < 2^CNT_W.
- `clk` input, 1 bit: system clock, 50 MHz. All logic is on its rising edge.
- `rst` input, 1 bit: reset, synchronous, active-high.
- `sig_in` input, 1 bit: asynchronous signal to measure.
- `period` output, CNT_W bits: clk cycles between the last two detected rising edges.
- `high_time` output, CNT_W bits: clk cycles from a rising edge to the following falling edge, for the period just reported.
- `period_valid` output, 1 bit: one-cycle pulse when `period` and `high_time` update.
- `timeout` output, 1 bit: level; set when no rising edge arrives within TIMEOUT cycles.

## Operation
- **Input synchronizer**
  - `sig_in` passes through two flops (s1, s2), then a third flop s3.
  - `rise = s2 & ~s3`; `fall = ~s2 & s3`.
- **Cycle counter `cnt`** (CNT_W bits)
  - Loads 1 on `rise`; otherwise increments.
  - Saturates at TIMEOUT and never wraps.
- **State machine**
  - ARM (reset state): waiting for the first rising edge. On `rise`, go to MEASURE with `cnt` <= 1. No result is reported.
  - MEASURE:
    - On `fall`, capture `hi_tmp` <= `cnt`.
    - On `rise`:
      - `period` <= `cnt`; `high_time` <= `hi_tmp`; pulse `period_valid`.
      - `cnt` <= 1; stay in MEASURE.
    - Else if `cnt == TIMEOUT`: go to STALLED and set `timeout` <= 1.
  - STALLED: `cnt` holds. On `rise`, clear `timeout`, go to MEASURE with `cnt` <= 1. No result is reported for this edge.
- **Simultaneous events**
  - `rise` in the same cycle as `cnt == TIMEOUT`: the rise wins. It reports `period` = TIMEOUT and does not enter STALLED.
  - `rise` and `fall` cannot coincide.
- **Held results**
  - `period` and `high_time` keep their last values across STALLED.
  - They change only when `period_valid` pulses.
- **Reset**, when `rst` = 1 at a clk edge:
  - s1, s2, s3, `cnt`, `hi_tmp` <= 0; state <= ARM.
  - `period` = 0, `high_time` = 0, `period_valid` = 0, `timeout` = 0.
  - A reset mid-measurement discards the partial count.
  - If `sig_in` is high at reset release, the resulting synchronizer 0→1 counts as the arming edge.

## Timing
- Let edge k be the first clk edge that samples `sig_in` = 1 into s1.
  - s2 = 1 after edge k+1, so `rise` is true in the following cycle.
  - `period` and `period_valid` update at edge k+2.
  - Input-to-result latency is 2 clk cycles after the sampling edge.
- `period_valid` is high for exactly one cycle per reported period.
- `timeout` rises at the edge after the cycle in which `cnt == TIMEOUT` with no `rise`. It falls at the edge that acts on the next `rise`.
- Resolution is ±1 clk cycle because the input is asynchronous.
- Minimum measurable `period` is 2. Input pulses shorter than 2 clk cycles may be missed.

## Configuration
- `PERIOD_METER_DUTY_EN`
  - Defined: high-time capture (`hi_tmp`, `fall` path) is compiled in, as described above.
  - Undefined: that logic is removed and `high_time` is tied to 0. `period`, `period_valid` and `timeout` are unchanged.

## Test plan
Parameters for all scenarios: CNT_W = 8, TIMEOUT = 20, duty enabled unless stated.

- **Steady square wave.** Reset, then drive `sig_in` with period 10 and high 4. Required: the first rising edge gives no pulse. Every later rise pulses `period_valid` once with `period` = 10 and `high_time` = 4, with latency 2 cycles from the sampling edge.
- **Stall.** Square wave with period 10, then hold `sig_in` low. Required: `timeout` = 1 exactly 20 cycles after the last `rise` cycle plus 1, and `period` holds 10. On the next rising edge, `timeout` clears and no pulse occurs. The following edge 12 cycles later reports `period` = 12.
- **Boundary.** Rising edges exactly 20 cycles apart. Required: `period` = 20 is reported and `timeout` stays 0. At 21 cycles apart, `timeout` is set and no pulse occurs.
- **Reset mid-measurement.** Assert `rst` for 1 cycle 5 cycles after a rise. Required: all outputs are 0 the next cycle and state is ARM. The next rise arms only; the following rise reports the correct period.
- **Duty disabled.** Build without `PERIOD_METER_DUTY_EN` and run the steady square wave. Required: `period` = 10 and `high_time` = 0 throughout.
